// File: rtl/clk_sel_ctrl_if.sv
// Request handshake and status bundle between a clock-select requester and clk_sel_ctrl.
interface clk_sel_ctrl_if;
    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic       sel;
    logic       busy;
    logic       done;
    logic [7:0] sw_cnt;

    modport master (
        output req_valid, req_sel,
        input  req_ready, sel, busy, done, sw_cnt
    );

    modport slave (
        input  req_valid, req_sel,
        output req_ready, sel, busy, done, sw_cnt
    );
endinterface

// File: rtl/clk_sel_ctrl.sv
// Clock-select sequencer: registers a new sel for clk_switch2 and holds it for HOLD_CYC cycles.
//   state | meaning
//   IDLE  | ready for a request; sel stable
//   HOLD  | sel recently changed; hold_cnt counts down the settle window
module clk_sel_ctrl #(
    parameter int unsigned HOLD_CYC = 16,
    parameter logic        RST_SEL  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    clk_sel_ctrl_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  sw_cnt_q, sw_cnt_d;
    logic        req_ready;
    logic        handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            sel_q      <= RST_SEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign handshake = bus.req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sw_cnt_d   = sw_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (bus.req_sel != sel_q) begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_LOAD;
                        sel_d      = bus.req_sel;
                        busy_d     = 1'b1;
                        sw_cnt_d   = (sw_cnt_q == 8'hFF) ? sw_cnt_q : sw_cnt_q + 8'd1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == 16'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel leaves the block straight from its flop so the clock switch never sees a glitch
    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        bus.req_ready = req_ready;
        bus.sel    = sel_q;
        bus.busy   = busy_q;
        bus.done   = done_q;
        bus.sw_cnt = sw_cnt_q;
    end
endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed plus random stimulus for clk_sel_ctrl against a cycle-count reference model.
module tb_clk_sel_ctrl;
    localparam int   HOLD = 16;
    localparam logic RSEL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    clk_sel_ctrl_if bus ();

    clk_sel_ctrl #(.HOLD_CYC(HOLD), .RST_SEL(RSEL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // model: busy_left = busy cycles still to come, zero means idle
    logic m_sel = RSEL;
    int   m_busy_left = 0;
    logic m_done = 1'b0;
    int   m_cnt = 0;
    int   changes = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic r);
        logic m_ready;
        bus.req_valid = v;
        bus.req_sel   = s;
        rst           = r;
        #3;
        m_ready = (m_busy_left == 0) && !r;
        chk("req_ready", {15'd0, bus.req_ready}, {15'd0, m_ready});
        @(posedge clk);
        if (r) begin
            m_sel = RSEL; m_busy_left = 0; m_done = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) m_done = 1'b1;
            end else if (v) begin
                if (s != m_sel) begin
                    m_sel = s;
                    m_busy_left = HOLD;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    changes++;
                end else begin
                    m_done = 1'b1;
                end
            end
        end
        #1;
        chk("sel",    {15'd0, bus.sel},  {15'd0, m_sel});
        chk("busy",   {15'd0, bus.busy}, {15'd0, (m_busy_left > 0)});
        chk("done",   {15'd0, bus.done}, {15'd0, m_done});
        chk("sw_cnt", {8'd0, bus.sw_cnt}, 16'(m_cnt));
    endtask

    initial begin
        int busy_cycles;
        int done_at;
        bus.req_valid = 1'b0;
        bus.req_sel   = 1'b0;
        @(posedge clk); #1;

        // reset 3 cycles then release
        repeat (3) step(0, 0, 1);
        step(0, 0, 0);

        // single change: measure busy width and done position explicitly
        step(1, 1, 0);
        busy_cycles = 1;
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0);
            if (bus.busy) busy_cycles++;
            if (bus.done) done_at = i;
        end
        chk("busy_width", 16'(busy_cycles), 16'(HOLD));
        chk("done_pos",   16'(done_at),     16'(HOLD));
        chk("cnt_after_1", {8'd0, bus.sw_cnt}, 16'd1);

        // held request during hold is ignored, then accepted at the done cycle
        step(0, 0, 1);
        step(1, 1, 0);
        for (int i = 0; i < HOLD + 2; i++) step(1, 0, 0);
        for (int i = 0; i < HOLD + 2; i++) step(0, 0, 0);
        chk("cnt_after_2", {8'd0, bus.sw_cnt}, 16'd2);

        // same-value request: done only
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("same_done", {15'd0, bus.done}, 16'd1);

        // reset mid-hold when hold_cnt would be 7
        step(1, 1, 0);
        repeat (8) step(0, 0, 0);
        step(0, 0, 1);
        chk("abort_sel", {15'd0, bus.sel}, {15'd0, RSEL});
        step(0, 0, 0);
        step(0, 0, 0);

        // 300 back-to-back changes, saturating counter
        changes = 0;
        for (int i = 0; i < 400 * (HOLD + 1) && changes < 300; i++) step(1, ~m_sel, 0);
        chk("changes_done", 16'(changes), 16'd300);
        chk("cnt_sat", {8'd0, bus.sw_cnt}, 16'd255);

        // random traffic with occasional reset
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 2));
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
